// File: rtl/exe_div_if.sv
// EXE <-> divider handshake bundle: operands and control in, stall/ready/results out.
interface exe_div_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_cancel;
  logic        stallreq_exe;
  logic        div_ready;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  modport master (
    output div_start, div_signed, div_opdata1, div_opdata2, div_cancel,
    input  stallreq_exe, div_ready, div_hi, div_lo
  );

  modport slave (
    input  div_start, div_signed, div_opdata1, div_opdata2, div_cancel,
    output stallreq_exe, div_ready, div_hi, div_lo
  );
endinterface

// File: rtl/exe_div.sv
// exe_div: 32-bit restoring radix-2 divider for DIV/DIVU, one quotient bit per cycle.
// Optional macro DIV_BYZERO_FAST_EN: a zero divisor completes in one cycle with hi=lo=0.
module exe_div (
  input  logic     cpu_clk_50M,
  input  logic     cpu_rst,
  exe_div_if.slave div_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_END  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [5:0]  cnt_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic [31:0] rem_r;
  logic        dvd_neg_r;
  logic        dvs_neg_r;
  logic        div_ready_r;
  logic [31:0] div_hi_r;
  logic [31:0] div_lo_r;

  logic [32:0] trial_s;
  logic [31:0] rem_nxt_s;
  logic [31:0] quo_nxt_s;
  logic [31:0] res_lo_s;
  logic [31:0] res_hi_s;
  logic        start_s;
  logic        zero_div_s;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic c);
    neg_if = c ? (~v + 32'd1) : v;
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    mag = neg_if(v, is_signed & v[31]);
  endfunction

  assign start_s = div_bus.div_start & ~div_bus.div_cancel;

`ifdef DIV_BYZERO_FAST_EN
  assign zero_div_s = (div_bus.div_opdata2 == 32'd0);
`else
  assign zero_div_s = 1'b0;
`endif

  // State register
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a flush wins over everything except reset
  always_comb begin
    state_nxt_s = state_r;
    if (div_bus.div_cancel) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_bus.div_start) begin
            if (zero_div_s) begin
              state_nxt_s = ST_END;
            end else begin
              state_nxt_s = ST_ON;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ON: begin
          if (cnt_r == 6'd31) begin
            state_nxt_s = ST_END;
          end else begin
            state_nxt_s = ST_ON;
          end
        end
        ST_END:  state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits
  always_comb begin
    trial_s = {rem_r, quo_r[31]} - {1'b0, dvs_r};
    if (trial_s[32] == 1'b0) begin
      rem_nxt_s = trial_s[31:0];
      quo_nxt_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_nxt_s = {rem_r[30:0], quo_r[31]};
      quo_nxt_s = {quo_r[30:0], 1'b0};
    end
  end

  // Final sign fix-up; outside ON the only route into END is the zero-divisor shortcut
  always_comb begin
    res_lo_s = 32'd0;
    res_hi_s = 32'd0;
    if (state_r == ST_ON) begin
      res_lo_s = neg_if(quo_nxt_s, dvd_neg_r ^ dvs_neg_r);
      res_hi_s = neg_if(rem_nxt_s, dvd_neg_r);
    end else begin
      res_lo_s = 32'd0;
      res_hi_s = 32'd0;
    end
  end

  // Datapath: operand capture, iteration, and result registers loaded on entry to END
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      cnt_r       <= 6'd0;
      quo_r       <= 32'd0;
      dvs_r       <= 32'd0;
      rem_r       <= 32'd0;
      dvd_neg_r   <= 1'b0;
      dvs_neg_r   <= 1'b0;
      div_ready_r <= 1'b0;
      div_hi_r    <= 32'd0;
      div_lo_r    <= 32'd0;
    end else begin
      div_ready_r <= (state_nxt_s == ST_END);
      if (state_nxt_s == ST_END) begin
        div_lo_r <= res_lo_s;
        div_hi_r <= res_hi_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            quo_r     <= mag(div_bus.div_opdata1, div_bus.div_signed);
            dvs_r     <= mag(div_bus.div_opdata2, div_bus.div_signed);
            dvd_neg_r <= div_bus.div_signed & div_bus.div_opdata1[31];
            dvs_neg_r <= div_bus.div_signed & div_bus.div_opdata2[31];
            rem_r     <= 32'd0;
            cnt_r     <= 6'd0;
          end
        end
        ST_ON: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          cnt_r <= cnt_r + 6'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Outputs: stall is combinational so EXE freezes in the start cycle itself
  always_comb begin
    div_bus.stallreq_exe = ~cpu_rst & div_bus.div_start & (state_r != ST_END)
                           & ~div_bus.div_cancel;
    div_bus.div_ready    = div_ready_r;
    div_bus.div_hi       = div_hi_r;
    div_bus.div_lo       = div_lo_r;
  end

endmodule

// File: tb/tb_exe_div.sv
// Directed self-checking bench for exe_div: timing, signed/unsigned results, cancel, reset.
module tb_exe_div;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc_cnt = 0;
  int unsigned last_rdy_abs = 0;
  int unsigned first_rdy_abs = 0;

  exe_div_if bus ();

  exe_div u_dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .div_bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

`ifdef DIV_BYZERO_FAST_EN
  localparam int          ZCYC = 1;
  localparam logic [31:0] ZLO  = 32'd0;
  localparam logic [31:0] ZHI  = 32'd0;
`else
  localparam int          ZCYC = 33;
  localparam logic [31:0] ZLO  = 32'hFFFF_FFFF;
  localparam logic [31:0] ZHI  = 32'd5;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Starts a division at the next cycle, returns at the falling edge of the ready cycle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_cyc);
    int rc;
    int sc;
    rc = -1;
    sc = 0;
    @(posedge clk); #1;
    bus.div_start   = 1'b1;
    bus.div_signed  = sgn;
    bus.div_opdata1 = a;
    bus.div_opdata2 = b;
    bus.div_cancel  = 1'b0;
    for (int c = 0; c < 40 && rc < 0; c++) begin
      @(negedge clk);
      if (bus.stallreq_exe) sc++;
      if (bus.div_ready) begin
        rc = c;
        last_rdy_abs = cyc_cnt;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_ready_cycle"}, 32'(rc), 32'(exp_cyc));
    chk({tag, "_stall_cycles"}, 32'(sc), 32'(exp_cyc));
    chk({tag, "_lo"}, bus.div_lo, exp_lo);
    chk({tag, "_hi"}, bus.div_hi, exp_hi);
  endtask

  task automatic idle_step(input string tag);
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_single"}, {31'd0, bus.div_ready}, 32'd0);
    chk({tag, "_stall_idle"}, {31'd0, bus.stallreq_exe}, 32'd0);
  endtask

  initial begin
    int hits;

    // Reset, with start already asserted: stall must stay low
    rst             = 1'b1;
    bus.div_start   = 1'b1;
    bus.div_signed  = 1'b0;
    bus.div_opdata1 = 32'd100;
    bus.div_opdata2 = 32'd7;
    bus.div_cancel  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", {31'd0, bus.stallreq_exe}, 32'd0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.div_start = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.div_ready}, 32'd0);
    chk("rst_hi", bus.div_hi, 32'd0);
    chk("rst_lo", bus.div_lo, 32'd0);

    // Idle with start low
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.stallreq_exe || bus.div_ready) hits++;
    end
    chk("idle_quiet", 32'(hits), 32'd0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    idle_step("divu_100_7");
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    idle_step("div_m7_2");
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    idle_step("div_min_m1");
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, ZLO, ZHI, ZCYC);
    idle_step("divu_5_0");
    run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 33);
    idle_step("divu_max_16");
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33);
    idle_step("div_100_m7");

    // Cancel in cycle 10; a restart in cycle 11 must take the full 33 cycles
    hits = 0;
    @(posedge clk); #1;
    bus.div_start   = 1'b1;
    bus.div_signed  = 1'b0;
    bus.div_opdata1 = 32'd50;
    bus.div_opdata2 = 32'd5;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) bus.div_cancel = 1'b1;
      @(negedge clk);
      if (bus.div_ready) hits++;
      if (c < 10 && !bus.stallreq_exe) hits++;
      if (c == 10) chk("cancel_stall", {31'd0, bus.stallreq_exe}, 32'd0);
      if (c < 10) begin
        @(posedge clk); #1;
      end
    end
    chk("cancel_no_ready", 32'(hits), 32'd0);
    chk("cancel_keep_lo", bus.div_lo, 32'hFFFF_FFF2);
    chk("cancel_keep_hi", bus.div_hi, 32'd2);
    run_div("after_cancel", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33);
    idle_step("after_cancel");

    // Reset in cycle 20 of a division
    @(posedge clk); #1;
    bus.div_start   = 1'b1;
    bus.div_signed  = 1'b0;
    bus.div_opdata1 = 32'd1000;
    bus.div_opdata2 = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_stall", {31'd0, bus.stallreq_exe}, 32'd0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.div_start = 1'b0;
    @(negedge clk);
    chk("midrst_lo", bus.div_lo, 32'd0);
    chk("midrst_hi", bus.div_hi, 32'd0);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_ready) hits++;
    end
    chk("midrst_no_ready", 32'(hits), 32'd0);
    run_div("after_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    idle_step("after_rst_9_3");

    // Back-to-back: start stays high into the cycle after END
    run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    first_rdy_abs = last_rdy_abs;
    run_div("b2b_10_4", 1'b0, 32'd10, 32'd4, 32'd2, 32'd2, 33);
    chk("b2b_spacing", 32'(last_rdy_abs - first_rdy_abs), 32'd34);
    idle_step("b2b_10_4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_div.md
EXE_DIV -- requirements
Module: exe_div

Interface
REQ-001 SHALL have port: cpu_clk_50M  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: cpu_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: div_start  input  1  EXE holds a DIV/DIVU; held high with stable operands until ready.
REQ-004 SHALL have port: div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have port: div_opdata1  input  32  dividend.
REQ-006 SHALL have port: div_opdata2  input  32  divisor.
REQ-007 SHALL have port: div_cancel  input  1  flush; abort current division.
REQ-008 SHALL have port: stallreq_exe  output  1  stall request to stall control; active-high (STOP).
REQ-009 SHALL have port: div_ready  output  1  result valid, one-cycle pulse.
REQ-010 SHALL have port: div_hi  output  32  remainder.
REQ-011 SHALL have port: div_lo  output  32  quotient.

Function
REQ-012 SHALL implement states IDLE, ON, END; restoring radix-2 division, one quotient bit per cycle, 6-bit iteration counter.
REQ-013 SHALL in IDLE with div_start=1 and no cancel: latch operand magnitudes (abs for signed, raw for unsigned), operand signs, clear partial remainder and counter, go to ON.
REQ-014 SHALL in ON perform one shift/subtract per cycle; after the 32nd iteration go to END.
REQ-015 SHALL on entering END register div_lo = quotient, negated if signed and operand signs differ; div_hi = remainder, negated if signed and dividend negative.
REQ-016 SHALL in END assert div_ready for exactly that cycle, then return to IDLE unconditionally.
REQ-017 SHALL drive stallreq_exe = div_start AND NOT(state == END) AND NOT div_cancel, combinationally.
REQ-018 SHALL hold stallreq_exe high for exactly 33 cycles per division (start cycle + 32 ON cycles); div_ready high in cycle 33 counting start cycle as 0.
REQ-019 SHALL hold div_hi/div_lo stable from END until the next division's END or reset.
REQ-020 SHALL on div_cancel=1 in any state go to IDLE next cycle, no div_ready pulse, results unchanged.
REQ-021 SHALL accept back-to-back divisions: div_start high in the cycle after END starts a new division from IDLE.
REQ-022 SHALL ignore div_start=0 in IDLE (no state change, stallreq_exe=0).
REQ-023 SHALL treat signed 0x80000000 / 0xFFFFFFFF as magnitude 2^31 / 1: div_lo=0x80000000, div_hi=0.

Reset
REQ-024 SHALL on cpu_rst=1 at a clock edge set state IDLE, counter 0, div_hi=0, div_lo=0, div_ready=0, regardless of state.
REQ-025 SHALL drive stallreq_exe=0 while cpu_rst=1.

Configuration
REQ-026 SHALL honour macro DIV_BYZERO_FAST_EN.
REQ-027 SHALL with DIV_BYZERO_FAST_EN defined: divisor 0 in IDLE goes directly to END; div_hi=0, div_lo=0; stallreq_exe high 1 cycle, div_ready in cycle 1.
REQ-028 SHALL without DIV_BYZERO_FAST_EN: divisor 0 runs full 32 iterations; unsigned result div_lo=0xFFFFFFFF, div_hi=dividend; timing per REQ-018.

Verification
REQ-029 SHALL cover DIVU 100/7 -> stallreq_exe high cycles 0-32, div_ready cycle 33, div_lo=14, div_hi=2.
REQ-030 SHALL cover DIV -7/2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> div_lo=0x80000000, div_hi=0.
REQ-031 SHALL cover DIVU 5/0 -> with macro: ready cycle 1, hi=lo=0; without: ready cycle 33, lo=0xFFFFFFFF, hi=5.
REQ-032 SHALL cover div_cancel in cycle 10 -> IDLE cycle 11, no div_ready, stallreq_exe low from cycle 10, prior results kept.
REQ-033 SHALL cover cpu_rst in cycle 20 of a division -> IDLE, hi=lo=0, no div_ready; new DIVU 9/3 then yields lo=3, hi=0.
REQ-034 SHALL cover back-to-back DIVU 9/3 then 10/4 -> two ready pulses 34 cycles apart, results (3,0) then (2,2).
